spi_host_wb: RTL

Wishbone-controlled SPI master (mode 0, MSB first, byte-oriented) on the SoC bus at `clk`. It drives the initiator end of the same 4-wire link that the SPI device core terminates. The firmware can exercise the device core, protocol wrapper and loopback from the fabric, or talk to an external SPI peripheral on the PMOD. Chip-select is software-controlled, so multi-byte frames (command byte plus payload) stay inside a single CS assertion.

---
 rtl/spi_host_pkg.sv | 22 ++
 rtl/spi_host_shifter.sv | 88 ++++++++
 rtl/spi_host_wb.sv | 120 ++++++++++++
 3 files changed

// File: rtl/spi_host_pkg.sv
// Shared definitions for the Wishbone SPI host: register map,
// CSR bit positions and shifter FSM encoding.
package spi_host_pkg;

    localparam logic ADDR_CSR  = 1'b0;
    localparam logic ADDR_DATA = 1'b1;

    localparam int CSR_BUSY     = 0;
    localparam int CSR_CS_REQ   = 1;
    localparam int CSR_OVERRUN  = 2;
    localparam int CSR_RX_VALID = 3;
    localparam int CSR_DIV      = 8;

    localparam int DEFAULT_DIV = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH
    } state_e;

endpackage

// File: rtl/spi_host_shifter.sv
// Mode-0 byte shifter: half-period timing, bit count and MISO capture.
// done is high in the final cycle before the FSM re-enters IDLE.
module spi_host_shifter
    import spi_host_pkg::*;
#(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [7:0]           tx_byte,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic                 miso,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           rx_byte,
    output logic                 spi_clk,
    output logic                 spi_mosi
);

    state_e               state;
    logic [7:0]           shreg;
    logic [2:0]           bit_cnt;
    logic [DIV_WIDTH-1:0] half_cnt;
    logic                 rx_bit;
    logic                 half_end;

    assign half_end = (half_cnt == div);
    assign done     = (state == ST_HIGH) && half_end && (bit_cnt == 3'd7);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            half_cnt <= '0;
            rx_bit   <= 1'b0;
            rx_byte  <= '0;
            busy     <= 1'b0;
            spi_clk  <= 1'b0;
            spi_mosi <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_LOW;
                        shreg    <= tx_byte;
                        spi_mosi <= tx_byte[7];
                        bit_cnt  <= '0;
                        half_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                ST_LOW: begin
                    if (half_end) begin
                        state    <= ST_HIGH;
                        spi_clk  <= 1'b1;
                        rx_bit   <= miso;
                        half_cnt <= '0;
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (half_end) begin
                        shreg    <= {shreg[6:0], rx_bit};
                        spi_clk  <= 1'b0;
                        half_cnt <= '0;
                        // mosi keeps the last bit once the byte is done
                        if (bit_cnt == 3'd7) begin
                            state   <= ST_IDLE;
                            busy    <= 1'b0;
                            rx_byte <= {shreg[6:0], rx_bit};
                        end else begin
                            state    <= ST_LOW;
                            spi_mosi <= shreg[6];
                            bit_cnt  <= bit_cnt + 1'b1;
                        end
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/spi_host_wb.sv
// Wishbone-controlled SPI master: register decode, status flags,
// software chip-select with deferral while a byte is in flight.
module spi_host_wb
    import spi_host_pkg::*;
#(
    parameter int DIV_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_addr,
    input  logic [31:0] wb_wdata,
    output logic [31:0] wb_rdata,
    input  logic        wb_we,
    input  logic        wb_cyc,
    output logic        wb_ack,
    output logic        spi_clk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_cs_n
);

    localparam int WW = CSR_DIV + DIV_WIDTH;

    logic                 req_we;
    logic                 req_addr;
    logic [WW-1:0]        req_wdata;
    logic                 cs_req;
    logic                 overrun;
    logic                 rx_valid;
    logic [DIV_WIDTH-1:0] div;
    logic                 miso_m;
    logic                 miso_s;
    logic                 busy;
    logic                 done;
    logic [7:0]           rx_byte;
    logic                 ack_next;
    logic                 wr_csr;
    logic                 wr_data;
    logic                 rd_data;
    logic                 start;
    logic                 cs_req_next;
    logic [31:0]          csr_val;
    logic [31:0]          data_val;
    logic                 unused_wdata;

    assign unused_wdata = ^wb_wdata[31:WW];

    assign ack_next    = wb_cyc & ~wb_ack;
    assign wr_csr      = wb_ack & req_we & (req_addr == ADDR_CSR);
    assign wr_data     = wb_ack & req_we & (req_addr == ADDR_DATA);
    assign rd_data     = wb_ack & ~req_we & (req_addr == ADDR_DATA);
    assign start       = wr_data & ~busy;
    assign cs_req_next = wr_csr ? req_wdata[CSR_CS_REQ] : cs_req;
    assign data_val    = {rx_valid, 23'b0, rx_byte};

    always_comb begin
        csr_val                        = '0;
        csr_val[CSR_BUSY]              = busy;
        csr_val[CSR_CS_REQ]            = cs_req;
        csr_val[CSR_OVERRUN]           = overrun;
        csr_val[CSR_RX_VALID]          = rx_valid;
        csr_val[CSR_DIV +: DIV_WIDTH]  = div;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_ack    <= 1'b0;
            wb_rdata  <= '0;
            req_we    <= 1'b0;
            req_addr  <= 1'b0;
            req_wdata <= '0;
            cs_req    <= 1'b0;
            overrun   <= 1'b0;
            rx_valid  <= 1'b0;
            div       <= DIV_WIDTH'(DEFAULT_DIV);
            miso_m    <= 1'b0;
            miso_s    <= 1'b0;
            spi_cs_n  <= 1'b1;
        end else begin
            miso_m <= spi_miso;
            miso_s <= miso_m;
            wb_ack <= ack_next;
            // request is latched so side-effects land at the end of the ack cycle
            if (ack_next) begin
                req_we    <= wb_we;
                req_addr  <= wb_addr;
                req_wdata <= wb_wdata[WW-1:0];
                wb_rdata  <= (wb_addr == ADDR_DATA) ? data_val : csr_val;
            end else begin
                wb_rdata <= '0;
            end
            if (wr_csr) begin
                cs_req <= req_wdata[CSR_CS_REQ];
                div    <= req_wdata[CSR_DIV +: DIV_WIDTH];
                if (req_wdata[CSR_OVERRUN]) overrun <= 1'b0;
            end
            if (wr_data && busy) overrun <= 1'b1;
            if (done) rx_valid <= 1'b1;
            else if (rd_data) rx_valid <= 1'b0;
            if (!busy) spi_cs_n <= ~cs_req_next;
        end
    end

    spi_host_shifter #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .tx_byte (req_wdata[7:0]),
        .div     (div),
        .miso    (miso_s),
        .busy    (busy),
        .done    (done),
        .rx_byte (rx_byte),
        .spi_clk (spi_clk),
        .spi_mosi(spi_mosi)
    );

endmodule
